// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter of the multicycle MIPS.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DBG = 1'b1;

    // Wide enough for MEM_LAT and MAX_WAIT up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle; slave is the arbiter's view, master the environment's.
interface mem_port_arbiter_if #(
    parameter int WIDTH = 32
);

    logic             cpu_req;
    logic             cpu_we;
    logic [WIDTH-1:0] cpu_addr;
    logic [WIDTH-1:0] cpu_wd;
    logic [WIDTH-1:0] cpu_rd;
    logic             cpu_ack;

    logic             dbg_req;
    logic             dbg_we;
    logic [WIDTH-1:0] dbg_addr;
    logic [WIDTH-1:0] dbg_wd;
    logic [WIDTH-1:0] dbg_rd;
    logic             dbg_ack;

    logic             mem_en;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd,
        input  dbg_req, dbg_we, dbg_addr, dbg_wd,
        input  mem_rd,
        output cpu_rd, cpu_ack, dbg_rd, dbg_ack,
        output mem_en, mem_we, mem_addr, mem_wd
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd,
        output dbg_req, dbg_we, dbg_addr, dbg_wd,
        output mem_rd,
        input  cpu_rd, cpu_ack, dbg_rd, dbg_ack,
        input  mem_en, mem_we, mem_addr, mem_wd
    );

endinterface

// File: rtl/mem_port_arbiter_starve_cnt.sv
// Saturating count of CPU grants taken while the debug port waits; at_max forces a debug grant.
module arb_starve_cnt
    import mips_mem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);

    localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_Q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == MAX_Q);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the fixed-latency unified memory: CPU has priority,
// the starvation counter guarantees the debug/loader port eventually gets a slot.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(MEM_LAT);

    arb_state_t       state_q, state_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] lat_q, lat_d;
    logic             mem_en_q, mem_en_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wd_q, wd_d;
    logic [WIDTH-1:0] cpu_rd_q, cpu_rd_d;
    logic [WIDTH-1:0] dbg_rd_q, dbg_rd_d;
    logic             cpu_ack_q, cpu_ack_d;
    logic             dbg_ack_q, dbg_ack_d;

    logic any_req, dbg_wins, sel_we;
    logic cnt_inc, cnt_clr, at_max;

    assign any_req  = bus.cpu_req | bus.dbg_req;
    assign dbg_wins = bus.dbg_req & (~bus.cpu_req | at_max);
    assign sel_we   = dbg_wins ? bus.dbg_we : bus.cpu_we;

    arb_starve_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (cnt_inc),
        .clr_i   (cnt_clr),
        .at_max_o(at_max)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        we_d      = we_q;
        lat_d     = lat_q;
        mem_en_d  = mem_en_q;
        mem_we_d  = mem_we_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        cpu_rd_d  = cpu_rd_q;
        dbg_rd_d  = dbg_rd_q;
        cpu_ack_d = 1'b0;
        dbg_ack_d = 1'b0;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                // Starvation count only moves on arbitration edges.
                cnt_clr = ~bus.dbg_req | dbg_wins;
                cnt_inc = bus.cpu_req & bus.dbg_req & ~dbg_wins;
                if (any_req) begin
                    owner_d  = dbg_wins ? OWNER_DBG : OWNER_CPU;
                    we_d     = sel_we;
                    addr_d   = dbg_wins ? bus.dbg_addr : bus.cpu_addr;
                    wd_d     = dbg_wins ? bus.dbg_wd : bus.cpu_wd;
                    lat_d    = LAT_INIT;
                    mem_en_d = 1'b1;
                    mem_we_d = sel_we;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                lat_d = lat_q - CNT_W'(1);
                if (lat_q == CNT_W'(1)) begin
                    state_d  = ACK;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (owner_q == OWNER_CPU) begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_rd_d = bus.mem_rd;
                    end else begin
                        dbg_ack_d = 1'b1;
                        if (!we_q) dbg_rd_d = bus.mem_rd;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= OWNER_CPU;
            we_q      <= 1'b0;
            lat_q     <= '0;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            addr_q    <= '0;
            wd_q      <= '0;
            cpu_rd_q  <= '0;
            dbg_rd_q  <= '0;
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            lat_q     <= lat_d;
            mem_en_q  <= mem_en_d;
            mem_we_q  <= mem_we_d;
            addr_q    <= addr_d;
            wd_q      <= wd_d;
            cpu_rd_q  <= cpu_rd_d;
            dbg_rd_q  <= dbg_rd_d;
            cpu_ack_q <= cpu_ack_d;
            dbg_ack_q <= dbg_ack_d;
        end
    end

    assign bus.mem_en   = mem_en_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wd   = wd_q;
    assign bus.cpu_rd   = cpu_rd_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.dbg_rd   = dbg_rd_q;
    assign bus.dbg_ack  = dbg_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=3, both MAX_WAIT=4.
module tb_mem_port_arbiter;
    import mips_mem_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    mem_port_arbiter_if #(.WIDTH(W)) if1 ();
    mem_port_arbiter_if #(.WIDTH(W)) if3 ();

    mem_port_arbiter #(.WIDTH(W), .MEM_LAT(1), .MAX_WAIT(4)) u_l1 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    mem_port_arbiter #(.WIDTH(W), .MEM_LAT(3), .MAX_WAIT(4)) u_l3 (
        .clk(clk), .reset(reset), .bus(if3.slave));

    logic [1:0]        cpu_req_t, cpu_we_t, dbg_req_t, dbg_we_t;
    logic [1:0][W-1:0] cpu_addr_t, cpu_wd_t, dbg_addr_t, dbg_wd_t;
    logic [1:0]        o_cpu_ack, o_dbg_ack, o_mem_en, o_mem_we;
    logic [1:0][W-1:0] o_cpu_rd, o_dbg_rd, o_mem_addr, o_mem_wd;

    assign if1.cpu_req = cpu_req_t[0];   assign if3.cpu_req = cpu_req_t[1];
    assign if1.cpu_we = cpu_we_t[0];     assign if3.cpu_we = cpu_we_t[1];
    assign if1.cpu_addr = cpu_addr_t[0]; assign if3.cpu_addr = cpu_addr_t[1];
    assign if1.cpu_wd = cpu_wd_t[0];     assign if3.cpu_wd = cpu_wd_t[1];
    assign if1.dbg_req = dbg_req_t[0];   assign if3.dbg_req = dbg_req_t[1];
    assign if1.dbg_we = dbg_we_t[0];     assign if3.dbg_we = dbg_we_t[1];
    assign if1.dbg_addr = dbg_addr_t[0]; assign if3.dbg_addr = dbg_addr_t[1];
    assign if1.dbg_wd = dbg_wd_t[0];     assign if3.dbg_wd = dbg_wd_t[1];

    assign o_cpu_ack  = {if3.cpu_ack, if1.cpu_ack};
    assign o_dbg_ack  = {if3.dbg_ack, if1.dbg_ack};
    assign o_mem_en   = {if3.mem_en, if1.mem_en};
    assign o_mem_we   = {if3.mem_we, if1.mem_we};
    assign o_cpu_rd   = {if3.cpu_rd, if1.cpu_rd};
    assign o_dbg_rd   = {if3.dbg_rd, if1.dbg_rd};
    assign o_mem_addr = {if3.mem_addr, if1.mem_addr};
    assign o_mem_wd   = {if3.mem_wd, if1.mem_wd};

    // Memory model: a fixed pattern per address, overlaid by whatever has been written.
    function automatic logic [W-1:0] pat(input logic [W-1:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return (a * 32'h0100_0193) ^ 32'h5A5A_C3C3;
    endfunction

    bit       wv   [2][64];
    logic [W-1:0] wmem [2][64];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (o_mem_en[k] && o_mem_we[k]) begin
                wv[k][o_mem_addr[k][7:2]]   <= 1'b1;
                wmem[k][o_mem_addr[k][7:2]] <= o_mem_wd[k];
            end
        end
    end

    assign if1.mem_rd = wv[0][if1.mem_addr[7:2]] ? wmem[0][if1.mem_addr[7:2]] : pat(if1.mem_addr);
    assign if3.mem_rd = wv[1][if3.mem_addr[7:2]] ? wmem[1][if3.mem_addr[7:2]] : pat(if3.mem_addr);

    typedef struct packed {
        logic         owner;
        logic [W-1:0] rd;
    } exp_t;

    exp_t sb[$];

    task automatic run_access(input int k, input logic own, input logic we,
                              input logic [W-1:0] addr, input logic [W-1:0] wd,
                              output int lat, output int en_cyc, output int we_cyc,
                              output bit stable, output bit other_ack, output logic [W-1:0] rd_seen);
        @(negedge clk);
        if (own == OWNER_CPU) begin
            cpu_req_t[k] = 1'b1; cpu_we_t[k] = we; cpu_addr_t[k] = addr; cpu_wd_t[k] = wd;
        end else begin
            dbg_req_t[k] = 1'b1; dbg_we_t[k] = we; dbg_addr_t[k] = addr; dbg_wd_t[k] = wd;
        end
        lat = -1; en_cyc = 0; we_cyc = 0; stable = 1'b1; other_ack = 1'b0; rd_seen = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (o_mem_en[k]) begin
                en_cyc++;
                if (o_mem_we[k]) we_cyc++;
                if (o_mem_addr[k] !== addr || (we && o_mem_wd[k] !== wd)) stable = 1'b0;
            end
            if ((own == OWNER_CPU) ? o_dbg_ack[k] : o_cpu_ack[k]) other_ack = 1'b1;
            if ((own == OWNER_CPU) ? o_cpu_ack[k] : o_dbg_ack[k]) begin
                lat = i;
                rd_seen = (own == OWNER_CPU) ? o_cpu_rd[k] : o_dbg_rd[k];
                break;
            end
        end
        cpu_req_t[k] = 1'b0;
        dbg_req_t[k] = 1'b0;
    endtask

    task automatic test_reset();
        cpu_req_t = '0; cpu_we_t = '0; cpu_addr_t = '0; cpu_wd_t = '0;
        dbg_req_t = '0; dbg_we_t = '0; dbg_addr_t = '0; dbg_wd_t = '0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({o_cpu_ack[k], o_dbg_ack[k]} !== 2'b00) begin
                bad++; $display("FAIL reset_acks[%0d]: got %b want 00", k, {o_cpu_ack[k], o_dbg_ack[k]});
            end
            total++;
            if ({o_mem_en[k], o_mem_we[k]} !== 2'b00) begin
                bad++; $display("FAIL reset_mem_ctl[%0d]: got %b want 00", k, {o_mem_en[k], o_mem_we[k]});
            end
            total++;
            if (o_cpu_rd[k] !== '0 || o_dbg_rd[k] !== '0) begin
                bad++; $display("FAIL reset_rd[%0d]: got %h/%h want 0/0", k, o_cpu_rd[k], o_dbg_rd[k]);
            end
            total++;
            if (o_mem_addr[k] !== '0 || o_mem_wd[k] !== '0) begin
                bad++; $display("FAIL reset_mem_bus[%0d]: got %h/%h want 0/0", k, o_mem_addr[k], o_mem_wd[k]);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_cpu_read();
        int lat, en, wec; bit st, oth; logic [W-1:0] rd; exp_t e;
        sb.push_back('{OWNER_CPU, 32'hDEAD_BEEF});
        run_access(0, OWNER_CPU, 1'b0, 32'h10, 32'h0, lat, en, wec, st, oth, rd);
        e = sb.pop_front();
        total++; if (lat !== 2) begin bad++; $display("FAIL cpu_read_latency: got %0d want 2", lat); end
        total++; if (en !== 1 || wec !== 0) begin bad++; $display("FAIL cpu_read_mem_en: got en=%0d we=%0d want 1/0", en, wec); end
        total++; if (!st) begin bad++; $display("FAIL cpu_read_addr: got unstable want 0x10"); end
        total++; if (oth) begin bad++; $display("FAIL cpu_read_dbg_ack: got 1 want 0"); end
        total++; if (rd !== e.rd) begin bad++; $display("FAIL cpu_read_data: got %h want %h", rd, e.rd); end
    endtask

    task automatic test_dbg_write();
        int lat, en, wec; bit st, oth; logic [W-1:0] rd; exp_t e;
        sb.push_back('{OWNER_DBG, pat(32'h30)});
        run_access(1, OWNER_DBG, 1'b0, 32'h30, 32'h0, lat, en, wec, st, oth, rd);
        e = sb.pop_front();
        total++; if (lat !== 4) begin bad++; $display("FAIL dbg_read_latency: got %0d want 4", lat); end
        total++; if (rd !== e.rd) begin bad++; $display("FAIL dbg_read_data: got %h want %h", rd, e.rd); end
        sb.push_back('{OWNER_DBG, pat(32'h30)});
        run_access(1, OWNER_DBG, 1'b1, 32'h20, 32'h1234_5678, lat, en, wec, st, oth, rd);
        e = sb.pop_front();
        total++; if (lat !== 4) begin bad++; $display("FAIL dbg_write_latency: got %0d want 4", lat); end
        total++; if (en !== 3 || wec !== 3) begin bad++; $display("FAIL dbg_write_strobes: got en=%0d we=%0d want 3/3", en, wec); end
        total++; if (!st) begin bad++; $display("FAIL dbg_write_bus_stable: got unstable want addr 0x20 wd 0x12345678"); end
        total++; if (oth) begin bad++; $display("FAIL dbg_write_cpu_ack: got 1 want 0"); end
        total++; if (rd !== e.rd) begin bad++; $display("FAIL dbg_write_rd_held: got %h want %h", rd, e.rd); end
        total++;
        if (!wv[1][8] || wmem[1][8] !== 32'h1234_5678) begin
            bad++; $display("FAIL dbg_write_mem: got %h want 12345678", wmem[1][8]);
        end
    endtask

    task automatic test_contention();
        int seen; exp_t e; logic [W-1:0] rd;
        for (int n = 0; n < 10; n++) begin
            if (n % 5 == 4) sb.push_back('{OWNER_DBG, pat(32'h80)});
            else            sb.push_back('{OWNER_CPU, pat(32'h40)});
        end
        @(negedge clk);
        cpu_req_t[0] = 1'b1; cpu_we_t[0] = 1'b0; cpu_addr_t[0] = 32'h40;
        dbg_req_t[0] = 1'b1; dbg_we_t[0] = 1'b0; dbg_addr_t[0] = 32'h80;
        seen = 0;
        for (int i = 0; i < 80 && seen < 10; i++) begin
            @(negedge clk);
            total++;
            if (o_cpu_ack[0] && o_dbg_ack[0]) begin bad++; $display("FAIL contention_both_acks: got 11 want at most one"); end
            if (o_cpu_ack[0] || o_dbg_ack[0]) begin
                e = sb.pop_front();
                total++;
                if (o_dbg_ack[0] !== e.owner) begin
                    bad++; $display("FAIL contention_grant_%0d: got owner %b want %b", seen, o_dbg_ack[0], e.owner);
                end
                rd = e.owner ? o_dbg_rd[0] : o_cpu_rd[0];
                total++;
                if (rd !== e.rd) begin bad++; $display("FAIL contention_data_%0d: got %h want %h", seen, rd, e.rd); end
                seen++;
            end
        end
        cpu_req_t[0] = 1'b0; dbg_req_t[0] = 1'b0;
        total++; if (seen !== 10) begin bad++; $display("FAIL contention_grants: got %0d want 10", seen); end
        sb.delete();
    endtask

    task automatic test_req_drop();
        int lat; bit idle_bad; exp_t e;
        sb.push_back('{OWNER_CPU, pat(32'h44)});
        @(negedge clk);
        cpu_req_t[1] = 1'b1; cpu_we_t[1] = 1'b0; cpu_addr_t[1] = 32'h44;
        @(negedge clk);
        cpu_req_t[1] = 1'b0;
        lat = (o_cpu_ack[1]) ? 1 : -1;
        for (int i = 2; i <= 20 && lat < 0; i++) begin
            @(negedge clk);
            if (o_cpu_ack[1]) lat = i;
        end
        e = sb.pop_front();
        total++; if (lat !== 4) begin bad++; $display("FAIL drop_latency: got %0d want 4", lat); end
        total++; if (o_cpu_rd[1] !== e.rd) begin bad++; $display("FAIL drop_data: got %h want %h", o_cpu_rd[1], e.rd); end
        idle_bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_mem_en[1] || o_cpu_ack[1] || o_dbg_ack[1]) idle_bad = 1'b1;
        end
        total++; if (idle_bad) begin bad++; $display("FAIL drop_idle: got activity want none"); end
        total++; if (o_cpu_rd[1] !== e.rd) begin bad++; $display("FAIL drop_rd_held: got %h want %h", o_cpu_rd[1], e.rd); end
    endtask

    task automatic test_reset_mid_busy();
        int lat, en, wec; bit st, oth, ack_seen, idle_bad; logic [W-1:0] rd;
        @(negedge clk);
        dbg_req_t[1] = 1'b1; dbg_we_t[1] = 1'b1; dbg_addr_t[1] = 32'h60; dbg_wd_t[1] = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        total++; if (o_mem_en[1] !== 1'b1) begin bad++; $display("FAIL rst_busy_pre: got mem_en=%b want 1", o_mem_en[1]); end
        #2 reset = 1'b0;
        #1;
        total++;
        if (o_mem_en[1] !== 1'b0 || o_mem_we[1] !== 1'b0) begin
            bad++; $display("FAIL rst_async_mem: got en=%b we=%b want 0/0", o_mem_en[1], o_mem_we[1]);
        end
        dbg_req_t[1] = 1'b0; dbg_we_t[1] = 1'b0;
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (o_cpu_ack[1] || o_dbg_ack[1]) ack_seen = 1'b1;
        end
        reset = 1'b1;
        total++; if (ack_seen) begin bad++; $display("FAIL rst_no_ack: got ack want none"); end
        total++;
        if (o_cpu_rd[1] !== '0 || o_dbg_rd[1] !== '0) begin
            bad++; $display("FAIL rst_rd_clear: got %h/%h want 0/0", o_cpu_rd[1], o_dbg_rd[1]);
        end
        idle_bad = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (o_mem_en[1] || o_cpu_ack[1] || o_dbg_ack[1]) idle_bad = 1'b1;
        end
        total++; if (idle_bad) begin bad++; $display("FAIL rst_idle: got activity want none"); end
        run_access(1, OWNER_CPU, 1'b0, 32'h10, 32'h0, lat, en, wec, st, oth, rd);
        total++; if (lat !== 4 || en !== 3) begin bad++; $display("FAIL rst_recover: got lat=%0d en=%0d want 4/3", lat, en); end
        total++; if (rd !== 32'hDEAD_BEEF || oth || wec !== 0 || !st) begin
            bad++; $display("FAIL rst_recover_data: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_back_to_back();
        int t1, t2; exp_t e;
        sb.push_back('{OWNER_CPU, pat(32'h0)});
        sb.push_back('{OWNER_CPU, pat(32'h4)});
        @(negedge clk);
        cpu_req_t[0] = 1'b1; cpu_we_t[0] = 1'b0; cpu_addr_t[0] = 32'h0;
        t1 = -1; t2 = -1;
        for (int i = 1; i <= 30 && t2 < 0; i++) begin
            @(negedge clk);
            if (o_cpu_ack[0]) begin
                e = sb.pop_front();
                total++;
                if (o_cpu_rd[0] !== e.rd) begin bad++; $display("FAIL b2b_data: got %h want %h", o_cpu_rd[0], e.rd); end
                if (t1 < 0) begin
                    t1 = i;
                    cpu_addr_t[0] = 32'h4;
                end else begin
                    t2 = i;
                end
            end
        end
        cpu_req_t[0] = 1'b0;
        total++; if (t1 !== 2) begin bad++; $display("FAIL b2b_first_latency: got %0d want 2", t1); end
        total++; if (t2 - t1 !== 3) begin bad++; $display("FAIL b2b_spacing: got %0d want 3", t2 - t1); end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dbg_write();
        test_contention();
        test_req_drop();
        test_reset_mid_busy();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
